// File: rtl/bram_stream_reader.sv
// Sequential block-RAM read engine: walks a wrapping address window and streams
// the words out over valid/ready through a 2-entry buffer that absorbs read latency.
module bram_stream_reader #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 7
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  input  logic [RAM_WIDTH-1:0]     ram_data,
  output logic                     out_valid,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_last,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

  state_t                             state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]           addr_q, addr_d;
  logic [RAM_ADDR_BITS:0]             len_q, len_d;
  logic [RAM_ADDR_BITS:0]             issued_q, issued_d;
  logic                               inflight_q, inflight_d;
  logic                               inflight_last_q, inflight_last_d;
  logic [1:0][RAM_WIDTH-1:0]          buf_data_q, buf_data_d;
  logic [1:0]                         buf_last_q, buf_last_d;
  logic                               rd_ptr_q, rd_ptr_d;
  logic                               wr_ptr_q, wr_ptr_d;
  logic [1:0]                         count_q, count_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  always_comb begin
    pop       = (count_q != 2'd0) && out_ready;
    push      = inflight_q;
    // Credit check counts the word leaving this cycle so full-rate streaming works.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == READ) && (issued_q < len_q) && (occupancy < 3'd2);

    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    inflight_d      = issue;
    inflight_last_d = issue && (issued_q == (len_q - CNT_ONE));
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      addr_d   = addr_q + ADDR_ONE;
      issued_d = issued_q + CNT_ONE;
    end

    if (push) begin
      buf_data_d[wr_ptr_q] = ram_data;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          state_d  = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((count_d == 2'd0) && !inflight_d) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_data_q      <= '0;
      buf_last_q      <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  assign busy        = (state_q == READ) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign ram_enable  = issue;
  assign ram_address = addr_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = buf_data_q[rd_ptr_q];
  assign out_last    = out_valid && buf_last_q[rd_ptr_q];

endmodule
